// File: rtl/dispense_scheduler.sv
// Round-robin dispense scheduler: captures slot requests per channel and fires one
// motor output at a time for PULSE_CYCLES, then idles GAP_CYCLES. Optional manual requests: DISPENSE_SCHEDULER_MANUAL_EN.
module dispense_scheduler #(
  parameter int PULSE_CYCLES = 50000000,
  parameter int GAP_CYCLES   = 5000000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       morningP,
  input  logic       afternoonP,
  input  logic       eveningP,
  input  logic [3:0] chMorning,
  input  logic [3:0] chAfternoon,
  input  logic [3:0] chEvening,
  input  logic       hold,
`ifdef DISPENSE_SCHEDULER_MANUAL_EN
  input  logic       manualP,
  input  logic [1:0] manualCh,
`endif
  output logic [3:0] gpio_out,
  output logic [3:0] pending,
  output logic       busy,
  output logic       done,
  output logic       overrun
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FIRE = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [30:0] PULSE_LAST = 31'(PULSE_CYCLES - 1);
  localparam logic [30:0] GAP_LAST   = 31'(GAP_CYCLES - 1);

  state_t      state_r, state_s;
  logic [30:0] cnt_r, cnt_s;
  logic [1:0]  last_grant_r, last_grant_s;
  logic [3:0]  req_s, clear_s, gpio_s, pending_s;
  logic [1:0]  grant_idx_s, cand_s;
  logic        grant_found_s, busy_s, done_s, overrun_s;

  // Slot pulses gated by their channel masks, plus the optional manual request
  always_comb begin
    req_s = ({4{morningP}} & chMorning) | ({4{afternoonP}} & chAfternoon) |
            ({4{eveningP}} & chEvening);
`ifdef DISPENSE_SCHEDULER_MANUAL_EN
    req_s = req_s | (manualP ? (4'b0001 << manualCh) : 4'b0000);
`endif
  end

  // Round-robin search; scanning from the far end lets the nearest candidate win
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = 2'd0;
    cand_s        = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      cand_s        = last_grant_r + 2'd1 + 2'(k);
      grant_idx_s   = pending[cand_s] ? cand_s : grant_idx_s;
      grant_found_s = grant_found_s | pending[cand_s];
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    last_grant_s = last_grant_r;
    gpio_s       = gpio_out;
    clear_s      = 4'b0000;
    done_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (grant_found_s && !hold) begin
          state_s      = FIRE;
          cnt_s        = 31'd0;
          last_grant_s = grant_idx_s;
          gpio_s       = 4'b0001 << grant_idx_s;
          clear_s      = 4'b0001 << grant_idx_s;
          done_s       = (PULSE_LAST == 31'd0);
        end else begin
          gpio_s = 4'b0000;
        end
      end
      FIRE: begin
        if (cnt_r == PULSE_LAST) begin
          state_s = GAP;
          cnt_s   = 31'd0;
          gpio_s  = 4'b0000;
        end else begin
          cnt_s  = cnt_r + 31'd1;
          done_s = (cnt_s == PULSE_LAST);
        end
      end
      GAP: begin
        gpio_s = 4'b0000;
        if (cnt_r == GAP_LAST) begin
          state_s = IDLE;
          cnt_s   = 31'd0;
        end else begin
          cnt_s = cnt_r + 31'd1;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 31'd0;
        gpio_s  = 4'b0000;
      end
    endcase
    busy_s    = (state_s != IDLE);
    // A request landing on the bit being granted re-arms it rather than overrunning
    pending_s = (pending & ~clear_s) | req_s;
    overrun_s = overrun | (|(req_s & pending & ~clear_s));
  end

  // State, counter and registered outputs
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      cnt_r        <= 31'd0;
      last_grant_r <= 2'd3;
      gpio_out     <= 4'b0000;
      pending      <= 4'b0000;
      busy         <= 1'b0;
      done         <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      last_grant_r <= last_grant_s;
      gpio_out     <= gpio_s;
      pending      <= pending_s;
      busy         <= busy_s;
      done         <= done_s;
      overrun      <= overrun_s;
    end
  end

endmodule

// File: tb/tb_dispense_scheduler.sv
// Self-checking bench for dispense_scheduler: directed scenarios plus random slot
// traffic, compared each cycle against a countdown-based reference model.
module tb_dispense_scheduler;
  localparam int P = 4;
  localparam int G = 2;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b0;
  logic       morningP = 1'b0, afternoonP = 1'b0, eveningP = 1'b0;
  logic [3:0] chMorning = 4'd0, chAfternoon = 4'd0, chEvening = 4'd0;
  logic       hold = 1'b0;
`ifdef DISPENSE_SCHEDULER_MANUAL_EN
  logic       manualP = 1'b0;
  logic [1:0] manualCh = 2'd0;
`endif
  logic [3:0] gpio_out, pending;
  logic       busy, done, overrun;

  dispense_scheduler #(.PULSE_CYCLES(P), .GAP_CYCLES(G)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset),
    .morningP(morningP), .afternoonP(afternoonP), .eveningP(eveningP),
    .chMorning(chMorning), .chAfternoon(chAfternoon), .chEvening(chEvening),
    .hold(hold),
`ifdef DISPENSE_SCHEDULER_MANUAL_EN
    .manualP(manualP), .manualCh(manualCh),
`endif
    .gpio_out(gpio_out), .pending(pending), .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: pulse/gap expressed as remaining-cycle countdowns
  logic [3:0] m_pend;
  logic       m_over;
  int         m_last, m_fire, m_gap, m_ch;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend = 4'd0; m_over = 1'b0; m_last = 3; m_fire = 0; m_gap = 0; m_ch = 0;
  endtask

  task automatic model_edge(input logic [3:0] req, input logic h);
    logic [3:0] gbit;
    gbit = 4'd0;
    if (m_fire > 0) begin
      m_fire--;
      if (m_fire == 0) m_gap = G;
    end else if (m_gap > 0) begin
      m_gap--;
    end else if (m_pend != 4'd0 && !h) begin
      for (int k = 1; k <= 4; k++) begin
        int c;
        c = (m_last + k) % 4;
        if (m_pend[c] && gbit == 4'd0) begin
          gbit[c] = 1'b1;
          m_ch = c;
        end
      end
      m_last = m_ch;
      m_fire = P;
    end
    m_over = m_over | (|(req & m_pend & ~gbit));
    m_pend = (m_pend & ~gbit) | req;
  endtask

  task automatic check_outputs(input string tag);
    logic [3:0] exp_gpio;
    exp_gpio = (m_fire > 0) ? (4'd1 << m_ch) : 4'd0;
    check_eq({tag, ":gpio_out"}, {28'd0, gpio_out}, {28'd0, exp_gpio});
    check_eq({tag, ":pending"}, {28'd0, pending}, {28'd0, m_pend});
    check_eq({tag, ":busy"}, {31'd0, busy}, {31'd0, (m_fire > 0 || m_gap > 0)});
    check_eq({tag, ":done"}, {31'd0, done}, {31'd0, (m_fire == 1)});
    check_eq({tag, ":overrun"}, {31'd0, overrun}, {31'd0, m_over});
  endtask

  task automatic step(input logic mp, input logic ap, input logic ep,
                      input logic [3:0] cm, input logic [3:0] ca, input logic [3:0] ce,
                      input logic h, input logic man, input logic [1:0] mch, input string tag);
    logic [3:0] req;
    morningP = mp; afternoonP = ap; eveningP = ep;
    chMorning = cm; chAfternoon = ca; chEvening = ce; hold = h;
    req = ({4{mp}} & cm) | ({4{ap}} & ca) | ({4{ep}} & ce);
`ifdef DISPENSE_SCHEDULER_MANUAL_EN
    manualP = man; manualCh = mch;
    if (man) req[mch] = 1'b1;
`else
    if (man && mch == 2'd0) req = req | 4'd0;
`endif
    @(posedge CLOCK_50);
    model_edge(req, h);
    #1;
    check_outputs(tag);
  endtask

  task automatic idle(input int n, input logic h, input string tag);
    repeat (n) step(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, h, 1'b0, 2'd0, tag);
  endtask

  task automatic apply_reset(input string tag);
    reset = 1'b0;
    #1;
    model_reset();
    check_outputs(tag);
    @(negedge CLOCK_50);
    reset = 1'b1;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge CLOCK_50);
    #1;
    check_outputs("reset");
    @(negedge CLOCK_50);
    reset = 1'b1;

    // single morning request on channel 0
    idle(2, 1'b0, "quiet");
    step(1'b1, 1'b0, 1'b0, 4'b0001, 4'd0, 4'd0, 1'b0, 1'b0, 2'd0, "single");
    idle(10, 1'b0, "single");

    // all four channels from one afternoon pulse, then wrap to channel 0
    step(1'b0, 1'b1, 1'b0, 4'd0, 4'b1111, 4'd0, 1'b0, 1'b0, 2'd0, "rr");
    idle(28, 1'b0, "rr");
    step(1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'b0011, 1'b0, 1'b0, 2'd0, "wrap");
    idle(16, 1'b0, "wrap");

    // hold blocks a grant until released
    step(1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'b0100, 1'b1, 1'b0, 2'd0, "hold");
    idle(5, 1'b1, "hold");
    idle(10, 1'b0, "hold_rel");

    // duplicate request while pending -> sticky overrun
    step(1'b1, 1'b0, 1'b0, 4'b0010, 4'd0, 4'd0, 1'b1, 1'b0, 2'd0, "ovr");
    idle(1, 1'b1, "ovr");
    step(1'b1, 1'b0, 1'b0, 4'b0010, 4'd0, 4'd0, 1'b1, 1'b0, 2'd0, "ovr");
    idle(10, 1'b0, "ovr_sticky");
    step(1'b1, 1'b0, 1'b0, 4'b0010, 4'd0, 4'd0, 1'b0, 1'b0, 2'd0, "ovr_sticky");
    idle(10, 1'b0, "ovr_sticky");
    apply_reset("ovr_clear");

    // reset in the middle of a channel-2 pulse
    step(1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'b0100, 1'b0, 1'b0, 2'd0, "midrst");
    idle(3, 1'b0, "midrst");
    #2;
    apply_reset("midrst_async");
    idle(10, 1'b0, "post_rst");

`ifdef DISPENSE_SCHEDULER_MANUAL_EN
    step(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 2'd3, "manual");
    idle(10, 1'b0, "manual");
`endif

    // random slot traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
           4'($urandom), 4'($urandom), 4'($urandom), $urandom_range(0, 3) == 0,
           $urandom_range(0, 9) == 0, 2'($urandom), "rand");
      if (i == 1500) apply_reset("rand_rst");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/dispense_scheduler.md
DISPENSE_SCHEDULER -- requirements
Module: dispense_scheduler

Interface
REQ-001 Parameter PULSE_CYCLES, 50000000, number of cycles a granted channel output is held high (1 s at 50 MHz); legal range 1 to 2^31-1.
REQ-002 Parameter GAP_CYCLES, 5000000, number of idle cycles after each pulse before the next grant; legal range 1 to 2^31-1.
REQ-003 CLOCK_50  in  1  sole clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 morningP, afternoonP, eveningP  in  1 each  one-cycle dispense-slot pulses.
REQ-006 chMorning, chAfternoon, chEvening  in  4 each  per-channel slot enable masks; bit i = channel i.
REQ-007 hold  in  1  while high, no new grant starts.
REQ-008 gpio_out  out  4  motor drive; one-hot or zero.
REQ-009 pending  out  4  registered pending-request vector.
REQ-010 busy  out  1  high in FIRE or GAP.
REQ-011 done  out  1  one-cycle pulse on the last FIRE cycle.
REQ-012 overrun  out  1  sticky flag for a lost request.

Function
REQ-013 Request capture: pending[i] SHALL be set at edge t when, in cycle t, (morningP&chMorning[i]) | (afternoonP&chAfternoon[i]) | (eveningP&chEvening[i]) is true; simultaneous slot pulses OR together.
REQ-014 FSM states SHALL be IDLE, FIRE, GAP; reset state IDLE.
REQ-015 IDLE->FIRE SHALL occur at the edge where state=IDLE, pending!=0 and hold=0; the same edge SHALL clear the granted pending bit and assert its gpio_out bit.
REQ-016 Grant SHALL be round-robin: the lowest-index pending channel at or above (lastGrant+1) mod 4, wrapping; lastGrant SHALL reset to 3.
REQ-017 gpio_out[grant] SHALL be high for exactly PULSE_CYCLES cycles, with all other bits 0.
REQ-018 done SHALL be high on the final FIRE cycle; FIRE->GAP SHALL follow at that edge, with gpio_out=0.
REQ-019 The block SHALL stay in GAP for exactly GAP_CYCLES cycles, then go to IDLE.
REQ-020 Latency: a slot pulse in cycle t with an idle scheduler and hold=0 SHALL give gpio_out high from cycle t+2.
REQ-021 A request for channel i while pending[i]=1 SHALL set overrun; pending[i] stays 1.
REQ-022 A request for channel i on the same edge as its grant clears pending[i] SHALL leave pending[i]=1, with no overrun.
REQ-023 A request for the channel currently in FIRE or GAP SHALL set pending normally, with no overrun.
REQ-024 hold SHALL NOT abort FIRE or GAP, and SHALL NOT block request capture.
REQ-025 Cycle counters SHALL be 31 bits; no wrap is permitted within legal parameter ranges.

Reset
REQ-026 When reset=0, the block SHALL asynchronously force state=IDLE, gpio_out=0, pending=0, busy=0, done=0, overrun=0, lastGrant=3 and counters=0.
REQ-027 A reset during FIRE SHALL drop gpio_out within the same cycle; the interrupted request SHALL be lost, not resumed.
REQ-028 overrun SHALL clear only on reset.

Configuration
REQ-029 With DISPENSE_SCHEDULER_MANUAL_EN defined, the block SHALL add input manualP (1 bit) and input manualCh (2 bits); manualP=1 SHALL request channel manualCh, ignoring the masks, with REQ-021/022 rules applied.
REQ-030 Without DISPENSE_SCHEDULER_MANUAL_EN, those ports and that logic SHALL be absent, and behaviour SHALL be as REQ-013..028.

Verification (PULSE_CYCLES=4, GAP_CYCLES=2)
REQ-031 chMorning=0001, morningP pulse at cycle 10 -> pending=0001 at 11; gpio_out=0001 for cycles 12-15; done at 15; busy through 17; IDLE at 18.
REQ-032 chAfternoon=1111, afternoonP pulse -> grants in order 0,1,2,3; each 4-cycle pulse separated by 2 zero cycles; then eveningP with chEvening=0011 -> next grant is channel 0 (wrap after lastGrant=3).
REQ-033 hold=1 with pending=0100 -> gpio_out stays 0; release hold at cycle n -> gpio_out=0100 from n+1.
REQ-034 chMorning=0010, two morningP pulses 1 cycle apart while hold=1 -> overrun=1; a single pulse on pending[1] -> overrun stays 1 until reset.
REQ-035 reset=0 asserted mid-FIRE on channel 2 -> gpio_out=0 in the same cycle; pending=0; after release, no pulse without a new request.
REQ-036 With DISPENSE_SCHEDULER_MANUAL_EN defined: manualP with manualCh=3 and all masks 0 -> gpio_out=1000 two cycles later.
